// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned SEL_W        = 2;
  localparam int unsigned MAX_HOLD_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, searching upward and wrapping modulo NUM_REQ.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SEL_W-1:0]   i_rr_ptr,
  output logic [SEL_W-1:0]   o_winner,
  output logic               o_any_req
);

  logic [2*NUM_REQ-2:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [SEL_W-1:0]     w_off;

  // Rotate the request vector so the pointer position lands at bit 0.
  assign w_dbl = {i_req[NUM_REQ-2:0], i_req};
  assign w_rot = w_dbl[i_rr_ptr +: NUM_REQ];

  // Lowest set bit of the rotated vector is the offset from the pointer.
  always_comb begin
    w_off = '0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else if (w_rot[3]) w_off = 2'd3;
  end

  assign o_winner  = i_rr_ptr + w_off;
  assign o_any_req = |i_req;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for four requesters with a hold limit, driving a
// registered 4:1 data mux from the current owner.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               data_out
);

  localparam int unsigned          HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e          r_state, w_state_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [SEL_W-1:0]    r_sel, w_sel_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_data_out, w_data_out_nxt;
  logic [SEL_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;

  logic [SEL_W-1:0]    w_winner;
  logic                w_any_req;
  logic                w_release;
  logic                w_load;

  rr_pick u_rr_pick (
    .i_req     (req),
    .i_rr_ptr  (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_release = !req[r_sel] || (r_hold_cnt == HOLD_LAST);

  // Next-state, grant and counter logic; a release with requests pending
  // reloads a new grant on the same edge so there is no idle gap.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_sel_nxt      = r_sel;
    w_busy_nxt     = r_busy;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    w_load         = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_any_req) w_load = 1'b1;
      end
      GRANT: begin
        if (w_release) begin
          if (w_any_req) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
          end
        end else if (r_hold_cnt != HOLD_LAST) begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_load) begin
      w_state_nxt    = GRANT;
      w_gnt_nxt      = onehot(w_winner);
      w_sel_nxt      = w_winner;
      w_busy_nxt     = 1'b1;
      w_rr_ptr_nxt   = w_winner + 1'b1;
      w_hold_cnt_nxt = '0;
    end
  end

  // Registered mux output follows the owner selected on the previous edge.
  always_comb begin
    w_data_out_nxt = r_busy ? data_in[r_sel] : 1'b0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_sel      <= '0;
      r_busy     <= 1'b0;
      r_data_out <= 1'b0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
      r_busy     <= w_busy_nxt;
      r_data_out <= w_data_out_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign sel      = r_sel;
  assign busy     = r_busy;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter (MAX_HOLD=4 and MAX_HOLD=1 instances).
module tb_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] data_in;
  logic [3:0] gnt,  gnt1;
  logic [1:0] sel,  sel1;
  logic       busy, busy1;
  logic       data_out, data_out1;

  int unsigned n_checks;
  int unsigned n_pass;

  mux_arbiter #(.MAX_HOLD(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_in  (data_in),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .data_out (data_out)
  );

  mux_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_in  (data_in),
    .gnt      (gnt1),
    .sel      (sel1),
    .busy     (busy1),
    .data_out (data_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {busy, sel, gnt} for an active grant to requester idx.
  function automatic logic [6:0] granted(input int unsigned idx);
    logic [3:0] g;
    g = 4'b0001 << idx;
    return {1'b1, idx[1:0], g};
  endfunction

  logic [3:0] pat [10];
  logic [3:0] req_s;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    data_in  = 4'b0000;
    pat = '{4'h4, 4'h0, 4'hF, 4'hB, 4'h6, 4'h2, 4'h9, 4'hD, 4'h4, 4'h1};

    // Reset, with requests present that must be ignored.
    tick();
    req = 4'b1111;
    tick();
    check("reset_outs", {busy, sel, gnt, data_out}, 8'h00);
    check("reset_outs_mh1", {busy1, sel1, gnt1, data_out1}, 8'h00);

    // Single request from c: 1-cycle latency, then data mux.
    rst_n   = 1'b1;
    req     = 4'b0100;
    data_in = 4'b0100;
    tick();
    check("first_grant", {busy, sel, gnt}, 7'b1_10_0100);
    check("first_dout", data_out, 1'b0);
    tick();
    check("dout_c", data_out, 1'b1);
    check("hold_c", gnt, 4'b0100);
    req = 4'b0000;
    tick();
    check("release_idle", {busy, sel, gnt}, 7'b0_10_0000);
    check("release_dout", data_out, 1'b1);
    tick();
    check("idle_dout", data_out, 1'b0);

    // Full contention: rotation 0,1,2,3,0 with 4-cycle holds; MAX_HOLD=1 rotates every cycle.
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rot_mh4", {busy, sel, gnt}, granted((i / 4) % 4));
      check("rot_mh1", {busy1, sel1, gnt1}, granted(i % 4));
    end

    // Owner b drops after 2 cycles while d waits: handover without a gap.
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    check("b_grant", {busy, sel, gnt}, 7'b1_01_0010);
    tick();
    check("b_hold", {busy, sel, gnt}, 7'b1_01_0010);
    req = 4'b1000;
    tick();
    check("b_to_d", {busy, sel, gnt}, 7'b1_11_1000);
    data_in = 4'b1000;
    tick();
    check("dout_d", data_out, 1'b1);

    // Reset during grant to d aborts it; afterwards requester 0 wins first.
    rst_n = 1'b0;
    tick();
    check("midgrant_reset", {busy, sel, gnt, data_out}, 8'h00);
    rst_n = 1'b1;
    req   = 4'b1001;
    tick();
    check("restart_a", {busy, sel, gnt}, 7'b1_00_0001);

    // Lone requester c held: continuous grant, hold counter wraps every 4.
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
    req   = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      data_in = pat[i];
      tick();
      check("solo_gnt", {busy, sel, gnt}, 7'b1_10_0100);
      check("solo_hold", 32'(u_dut.r_hold_cnt), 32'(i % 4));
      check("solo_gnt_mh1", gnt1, 4'b0100);
      if (i > 0) check("solo_dout", data_out, pat[i][2]);
    end

    // Random traffic: structural invariants every cycle.
    for (int i = 0; i < 300; i++) begin
      req_s   = 4'($urandom);
      req     = req_s;
      data_in = 4'($urandom);
      tick();
      check("inv_onehot", {$onehot0(gnt), $onehot0(gnt1)}, 2'b11);
      check("inv_busy", {busy, busy1}, {(gnt != 4'b0), (gnt1 != 4'b0)});
      check("inv_gnt_sel", {(busy ? gnt[sel] : 1'b1), (busy1 ? gnt1[sel1] : 1'b1)}, 2'b11);
      check("inv_req", {(gnt & ~req_s), (gnt1 & ~req_s)}, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive grant cycles per owner before forced rotation (legal range 1..16).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: req  input  4  per-requester request; bit i = requester i (0=a, 1=b, 2=c, 3=d).
REQ-005 Port: data_in  input  4  per-requester data bit; bit i paired with req[i].
REQ-006 Port: gnt  output  4  registered one-hot grant; all-zero when no owner.
REQ-007 Port: sel  output  2  registered mux select {s1,s0} = index of current owner.
REQ-008 Port: busy  output  1  registered; 1 while a grant is active.
REQ-009 Port: data_out  output  1  registered, data_in[sel] sampled while busy.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 In IDLE with req != 0, the block SHALL select the winner as the first set req bit at or after rr_ptr, searching upward modulo 4.
REQ-012 On entry to GRANT, the block SHALL set gnt, sel and busy on the next edge; latency from req sample to gnt is 1 cycle.
REQ-013 On every grant, the block SHALL load rr_ptr with (winner+1) mod 4 and clear hold_cnt.
REQ-014 In GRANT, hold_cnt SHALL increment each cycle the owner keeps req high, saturating at MAX_HOLD-1.
REQ-015 In GRANT, the block SHALL release the owner when req[owner]=0 or hold_cnt = MAX_HOLD-1.
REQ-016 On release with another req pending, the block SHALL grant the next round-robin winner on the same edge, with no idle cycle between grants.
REQ-017 On expiry with only the owner requesting, the block SHALL re-grant the same owner, clear hold_cnt and advance rr_ptr.
REQ-018 On release with req = 0, the block SHALL go to IDLE: gnt=0000 and busy=0; sel holds its last value.
REQ-019 gnt SHALL be one-hot or zero in every cycle, and gnt[sel]=1 whenever busy=1.
REQ-020 While busy=1, data_out SHALL take data_in[sel] each edge, a one-cycle registered 4:1 mux output; in IDLE it SHALL hold 0.
REQ-021 A requester SHALL keep its grant only while its req bit is high; there is no grant without a request, except the single release cycle.
REQ-022 With MAX_HOLD=1, the block SHALL rotate every cycle among active requesters.
REQ-023 rr_ptr SHALL wrap from 3 to 0; hold_cnt width SHALL be ceil(log2(MAX_HOLD)), minimum 1 bit.

Reset
REQ-024 While rst_n=0 at a clock edge: state=IDLE, gnt=0000, sel=00, busy=0, data_out=0, rr_ptr=0, hold_cnt=0.
REQ-025 Reset asserted mid-grant SHALL abort the grant on that edge with no further outputs; arbitration after deassertion SHALL restart from requester 0.
REQ-026 The block SHALL ignore req while rst_n=0; the first grant SHALL occur 1 cycle after the first edge with rst_n=1 and req!=0.

Structure
REQ-027 Package mux_arb_pkg SHALL hold: NUM_REQ=4, SEL_W=2, the state enum {IDLE, GRANT}, and the MAX_HOLD default.
REQ-028 Round-robin selection SHALL live in a combinational sub-module rr_pick (inputs req, rr_ptr; outputs winner index, any_req), instantiated once.
REQ-029 The FSM, counters and output registers SHALL reside in mux_arbiter; there SHALL be no latches and no combinational paths from req to outputs.

Verification
REQ-030 Reset then req=0100 -> cycle+1: gnt=0100, sel=10, busy=1; data_in=0100 gives data_out=1 the following cycle.
REQ-031 req=1111 held, MAX_HOLD=4 -> owners 0,1,2,3,0, each granted exactly 4 consecutive cycles, with no gaps.
REQ-032 Owner 1 drops req after 2 cycles while req[3]=1 -> the next edge gives gnt=1000, sel=11, busy stays 1.
REQ-033 Only req[2] held for 10 cycles, MAX_HOLD=4 -> gnt=0100 continuously; hold_cnt restarts every 4 cycles.
REQ-034 rst_n=0 for one edge during a grant to requester 3 -> outputs zero that edge; with req=1001 after release, requester 0 wins first.
REQ-035 Random req/data, 10k cycles, assertions checking REQ-019, REQ-020 and REQ-021 -> no violations, every requester served within 3*MAX_HOLD cycles.
